// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector: FSM encoding,
// default sizes and the length-field width helper.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 8;

  // Length fields must hold the value MAX_LEN itself, hence the +1.
  function automatic int unsigned seq_det_len_w(input int unsigned max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_det_shreg.sv
// Qualified history shift register with length-masked pattern compare.
// o_hit_c reports whether history plus the incoming bit matches the pattern.
module seq_det_shreg
  import seq_det_pkg::*;
#(
  parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
  localparam int unsigned LEN_W   = seq_det_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_shift,
  input  logic               i_clr,
  input  logic               i_din,
  input  logic [MAX_LEN-1:0] i_pat,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_hit_c
);

  logic [MAX_LEN-1:0] r_hist;
  logic [MAX_LEN:0]   w_win;
  logic [MAX_LEN:0]   w_mask;

  assign w_win = {r_hist, i_din};

  // Low i_len bits set; the extra top bit only goes high for an out-of-range
  // length, which never reaches a compare because the FSM stays in IDLE then.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i <= int'(MAX_LEN); i++) begin
      w_mask[i] = (LEN_W'(i) < i_len);
    end
  end

  assign o_hit_c = ((w_win ^ {1'b0, i_pat}) & w_mask) == '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hist <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
    end else if (i_shift) begin
      r_hist <= w_win[MAX_LEN-1:0];
    end
  end

endmodule

// File: rtl/prog_seq_det.sv
// Run-time programmable serial sequence detector with registered match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module prog_seq_det
  import seq_det_pkg::*;
#(
  parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
`ifdef SEQ_DET_CNT_EN
  parameter  int unsigned CNT_W   = DEF_CNT_W,
`endif
  localparam int unsigned LEN_W   = seq_det_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_vld,
  input  logic               din,
  input  logic               cfg_wr,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  output logic               armed,
  output logic               cfg_err,
`ifdef SEQ_DET_CNT_EN
  output logic [CNT_W-1:0]   match_cnt,
`endif
  output logic               dout
);

  state_t             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_fill, w_fill_nxt;
  logic [MAX_LEN-1:0] r_pat, w_pat_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic               r_ovl, w_ovl_nxt;
  logic               r_armed, w_armed_nxt;
  logic               r_cfg_err, w_cfg_err_nxt;
  logic               r_dout, w_dout_nxt;

  logic               w_take;
  logic               w_cfg_ok;
  logic [LEN_W-1:0]   w_fill_inc;
  logic               w_hit_c;
  logic               w_match_c;
  logic               w_hist_clr;
  logic               w_hist_shift;

  // A bit is consumed only when configured and not overridden by cfg_wr.
  assign w_take     = din_vld && !cfg_wr && (r_state != IDLE);
  assign w_cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign w_fill_inc = (r_fill < r_len) ? LEN_W'(r_fill + 1'b1) : r_len;
  assign w_match_c  = w_take && (w_fill_inc == r_len) && w_hit_c;

  seq_det_shreg #(
    .MAX_LEN (MAX_LEN)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_hist_shift),
    .i_clr   (w_hist_clr),
    .i_din   (din),
    .i_pat   (r_pat),
    .i_len   (r_len),
    .o_hit_c (w_hit_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_fill    <= '0;
      r_pat     <= '0;
      r_len     <= '0;
      r_ovl     <= 1'b0;
      r_armed   <= 1'b0;
      r_cfg_err <= 1'b0;
      r_dout    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fill    <= w_fill_nxt;
      r_pat     <= w_pat_nxt;
      r_len     <= w_len_nxt;
      r_ovl     <= w_ovl_nxt;
      r_armed   <= w_armed_nxt;
      r_cfg_err <= w_cfg_err_nxt;
      r_dout    <= w_dout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fill_nxt    = r_fill;
    w_pat_nxt     = r_pat;
    w_len_nxt     = r_len;
    w_ovl_nxt     = r_ovl;
    w_cfg_err_nxt = 1'b0;
    w_dout_nxt    = 1'b0;
    w_hist_clr    = 1'b0;
    w_hist_shift  = 1'b0;

    if (cfg_wr) begin
      w_pat_nxt     = cfg_pat;
      w_len_nxt     = cfg_len;
      w_ovl_nxt     = cfg_ovl;
      w_fill_nxt    = '0;
      w_hist_clr    = 1'b1;
      w_state_nxt   = w_cfg_ok ? FILL : IDLE;
      w_cfg_err_nxt = !w_cfg_ok;
    end else if (w_take) begin
      w_dout_nxt = w_match_c;
      // Non-overlapping mode restarts collection from scratch after a match.
      if (w_match_c && !r_ovl) begin
        w_fill_nxt  = '0;
        w_hist_clr  = 1'b1;
        w_state_nxt = FILL;
      end else begin
        w_fill_nxt   = w_fill_inc;
        w_hist_shift = 1'b1;
        w_state_nxt  = (w_fill_inc == r_len) ? RUN : FILL;
      end
    end

    w_armed_nxt = (w_state_nxt != IDLE);
  end

  assign armed   = r_armed;
  assign cfg_err = r_cfg_err;
  assign dout    = r_dout;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_match_cnt, w_match_cnt_nxt;

  // Saturating match counter, cleared on every reconfiguration.
  always_comb begin
    w_match_cnt_nxt = r_match_cnt;
    if (cfg_wr) begin
      w_match_cnt_nxt = '0;
    end else if (w_match_c && (r_match_cnt != '1)) begin
      w_match_cnt_nxt = CNT_W'(r_match_cnt + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_match_cnt <= '0;
    end else begin
      r_match_cnt <= w_match_cnt_nxt;
    end
  end

  assign match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_prog_seq_det.sv
// Self-checking bench for prog_seq_det: per-cycle vector table plus
// hand-written reset and (with SEQ_DET_CNT_EN) counter sequences.
module tb_prog_seq_det;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;

  logic               clk;
  logic               rst;
  logic               din_vld;
  logic               din;
  logic               cfg_wr;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_ovl;
  logic               armed;
  logic               cfg_err;
  logic               dout;

  int checks;
  int failures;

`ifdef SEQ_DET_CNT_EN
  logic [1:0] match_cnt;
  prog_seq_det #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .cfg_wr(cfg_wr),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .armed(armed),
    .cfg_err(cfg_err), .match_cnt(match_cnt), .dout(dout)
  );
`else
  prog_seq_det #(.MAX_LEN(MAX_LEN)) u_dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .cfg_wr(cfg_wr),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .armed(armed),
    .cfg_err(cfg_err), .dout(dout)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             wr;
    logic [7:0]       pat;
    logic [3:0]       len;
    logic             ovl;
    logic             vld;
    logic             d;
    logic             e_dout;
    logic             e_armed;
    logic             e_err;
    string            tag;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic vec(input logic wr, input logic [7:0] pat, input logic [3:0] len,
                     input logic ovl, input logic vld, input logic d, input logic ed,
                     input logic ea, input logic ee, input string tag);
    vec_t v;
    v.wr = wr; v.pat = pat; v.len = len; v.ovl = ovl; v.vld = vld; v.d = d;
    v.e_dout = ed; v.e_armed = ea; v.e_err = ee; v.tag = tag;
    vq.push_back(v);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                     input logic ea, input logic ee, input string tag);
    vec(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0, ea, ee, tag);
  endtask

  task automatic bit_in(input logic d, input logic ed, input logic ea, input string tag);
    vec(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, d, ed, ea, 1'b0, tag);
  endtask

  task automatic gap(input logic ea, input string tag);
    vec(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, 1'b0, tag);
  endtask

  task automatic drive(input logic wr, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic vld, input logic d);
    cfg_wr = wr; cfg_pat = pat; cfg_len = len; cfg_ovl = ovl; din_vld = vld; din = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_armed", 32'(armed), 32'd0);
    chk("reset_cfg_err", 32'(cfg_err), 32'd0);
`ifdef SEQ_DET_CNT_EN
    chk("reset_cnt", 32'(match_cnt), 32'd0);
`endif
    rst = 1'b1;

    // Overlapping 101
    cfg(8'h05, 4'd3, 1'b1, 1'b1, 1'b0, "ovl_cfg");
    bit_in(1'b1, 1'b0, 1'b1, "ovl_b1");
    bit_in(1'b0, 1'b0, 1'b1, "ovl_b2");
    bit_in(1'b1, 1'b1, 1'b1, "ovl_b3");
    bit_in(1'b0, 1'b0, 1'b1, "ovl_b4");
    bit_in(1'b1, 1'b1, 1'b1, "ovl_b5");
    gap(1'b1, "ovl_idle");
    // Non-overlapping 101
    cfg(8'h05, 4'd3, 1'b0, 1'b1, 1'b0, "novl_cfg");
    bit_in(1'b1, 1'b0, 1'b1, "novl_b1");
    bit_in(1'b0, 1'b0, 1'b1, "novl_b2");
    bit_in(1'b1, 1'b1, 1'b1, "novl_b3");
    bit_in(1'b0, 1'b0, 1'b1, "novl_b4");
    bit_in(1'b1, 1'b0, 1'b1, "novl_b5");
    // Non-overlapping 0010
    cfg(8'h02, 4'd4, 1'b0, 1'b1, 1'b0, "n4_cfg");
    bit_in(1'b0, 1'b0, 1'b1, "n4_b1");
    bit_in(1'b0, 1'b0, 1'b1, "n4_b2");
    bit_in(1'b1, 1'b0, 1'b1, "n4_b3");
    bit_in(1'b0, 1'b1, 1'b1, "n4_b4");
    bit_in(1'b0, 1'b0, 1'b1, "n4_b5");
    bit_in(1'b1, 1'b0, 1'b1, "n4_b6");
    bit_in(1'b0, 1'b0, 1'b1, "n4_b7");
    // Overlapping 0010
    cfg(8'h02, 4'd4, 1'b1, 1'b1, 1'b0, "o4_cfg");
    bit_in(1'b0, 1'b0, 1'b1, "o4_b1");
    bit_in(1'b0, 1'b0, 1'b1, "o4_b2");
    bit_in(1'b1, 1'b0, 1'b1, "o4_b3");
    bit_in(1'b0, 1'b1, 1'b1, "o4_b4");
    bit_in(1'b0, 1'b0, 1'b1, "o4_b5");
    bit_in(1'b1, 1'b0, 1'b1, "o4_b6");
    bit_in(1'b0, 1'b1, 1'b1, "o4_b7");
    // Gaps between valid bits
    cfg(8'h05, 4'd3, 1'b0, 1'b1, 1'b0, "gap_cfg");
    bit_in(1'b1, 1'b0, 1'b1, "gap_b1");
    for (int i = 0; i < 3; i++) gap(1'b1, "gap_g1");
    bit_in(1'b0, 1'b0, 1'b1, "gap_b2");
    for (int i = 0; i < 3; i++) gap(1'b1, "gap_g2");
    bit_in(1'b1, 1'b1, 1'b1, "gap_b3");
    gap(1'b1, "gap_after");
    // Invalid lengths disarm and flag
    cfg(8'h05, 4'd3, 1'b1, 1'b1, 1'b0, "err_pre");
    cfg(8'h05, 4'd0, 1'b1, 1'b0, 1'b1, "err_len0");
    bit_in(1'b1, 1'b0, 1'b0, "err_b1");
    bit_in(1'b0, 1'b0, 1'b0, "err_b2");
    bit_in(1'b1, 1'b0, 1'b0, "err_b3");
    cfg(8'h05, 4'd9, 1'b1, 1'b0, 1'b1, "err_len9");
    gap(1'b0, "err_clear");
    // Full-length all-ones pattern
    cfg(8'hFF, 4'd8, 1'b1, 1'b1, 1'b0, "max_cfg");
    for (int i = 0; i < 7; i++) bit_in(1'b1, 1'b0, 1'b1, "max_fill");
    bit_in(1'b1, 1'b1, 1'b1, "max_b8");
    bit_in(1'b1, 1'b1, 1'b1, "max_b9");
    // cfg_wr wins over a coincident valid bit
    vec(1'b1, 8'h05, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "coin_cfg");
    bit_in(1'b0, 1'b0, 1'b1, "coin_b1");
    bit_in(1'b1, 1'b0, 1'b1, "coin_b2");
    bit_in(1'b0, 1'b0, 1'b1, "coin_b3");
    bit_in(1'b1, 1'b1, 1'b1, "coin_b4");
    // Length one
    cfg(8'h01, 4'd1, 1'b1, 1'b1, 1'b0, "len1_cfg");
    bit_in(1'b1, 1'b1, 1'b1, "len1_b1");
    bit_in(1'b0, 1'b0, 1'b1, "len1_b2");
    bit_in(1'b1, 1'b1, 1'b1, "len1_b3");
    bit_in(1'b1, 1'b1, 1'b1, "len1_b4");
    // Pattern bits above len ignored
    cfg(8'hF5, 4'd3, 1'b1, 1'b1, 1'b0, "dc_cfg");
    bit_in(1'b1, 1'b0, 1'b1, "dc_b1");
    bit_in(1'b0, 1'b0, 1'b1, "dc_b2");
    bit_in(1'b1, 1'b1, 1'b1, "dc_b3");
    // Reconfig mid-sequence discards the partial history
    cfg(8'h05, 4'd3, 1'b1, 1'b1, 1'b0, "mid_cfg1");
    bit_in(1'b1, 1'b0, 1'b1, "mid_b1");
    bit_in(1'b0, 1'b0, 1'b1, "mid_b2");
    cfg(8'h05, 4'd3, 1'b1, 1'b1, 1'b0, "mid_cfg2");
    bit_in(1'b1, 1'b0, 1'b1, "mid_b3");
    bit_in(1'b0, 1'b0, 1'b1, "mid_b4");
    bit_in(1'b1, 1'b1, 1'b1, "mid_b5");

    foreach (vq[k]) begin
      drive(vq[k].wr, vq[k].pat, vq[k].len, vq[k].ovl, vq[k].vld, vq[k].d);
      step();
      chk($sformatf("%s[%0d].dout", vq[k].tag, k), 32'(dout), 32'(vq[k].e_dout));
      chk($sformatf("%s[%0d].armed", vq[k].tag, k), 32'(armed), 32'(vq[k].e_armed));
      chk($sformatf("%s[%0d].cfg_err", vq[k].tag, k), 32'(cfg_err), 32'(vq[k].e_err));
    end

    // Reset mid-sequence, then the stream continues without reconfiguration
    drive(1'b1, 8'h05, 4'd3, 1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1); step();
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0); step();
    rst = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1); step();
    chk("rst_mid_dout", 32'(dout), 32'd0);
    chk("rst_mid_armed", 32'(armed), 32'd0);
`ifdef SEQ_DET_CNT_EN
    chk("rst_mid_cnt", 32'(match_cnt), 32'd0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
      step();
      chk($sformatf("rst_after_b%0d_dout", i), 32'(dout), 32'd0);
      chk($sformatf("rst_after_b%0d_armed", i), 32'(armed), 32'd0);
    end

`ifdef SEQ_DET_CNT_EN
    begin
      logic [1:0] exp_cnt [5];
      exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
      exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
      drive(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0); step();
      chk("cnt_cfg", 32'(match_cnt), 32'd0);
      for (int i = 0; i < 5; i++) begin
        drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1); step();
        chk($sformatf("cnt_m%0d", i + 1), 32'(match_cnt), 32'(exp_cnt[i]));
        chk($sformatf("cnt_m%0d_dout", i + 1), 32'(dout), 32'd1);
      end
      drive(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0); step();
      chk("cnt_clear", 32'(match_cnt), 32'd0);
    end
`endif

    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
